// File: rtl/buffer_elastico_operandos_if.sv
// Handshake bundle between the operand mux (producer), the elastic buffer and the ALU (consumer).
// The master side is the environment around the buffer; the slave side is the buffer itself.
interface buffer_elastico_operandos_if #(
    parameter int ANCHO     = 16,
    parameter int ANCHO_ETQ = 2,
    parameter int ANCHO_CNT = 8
);
    logic [ANCHO-1:0]     Entrada;
    logic [ANCHO_ETQ-1:0] EtiquetaEntrada;
    logic                 ValidoEntrada;
    logic                 ListoEntrada;
    logic                 Vaciar;
    logic [ANCHO-1:0]     Salida;
    logic [ANCHO_ETQ-1:0] EtiquetaSalida;
    logic                 ValidoSalida;
    logic                 ListoSalida;
    logic [1:0]           Ocupacion;
    logic [ANCHO_CNT-1:0] ContadorEsperas;

    modport master (
        output Entrada, EtiquetaEntrada, ValidoEntrada, Vaciar, ListoSalida,
        input  ListoEntrada, Salida, EtiquetaSalida, ValidoSalida, Ocupacion, ContadorEsperas
    );

    modport slave (
        input  Entrada, EtiquetaEntrada, ValidoEntrada, Vaciar, ListoSalida,
        output ListoEntrada, Salida, EtiquetaSalida, ValidoSalida, Ocupacion, ContadorEsperas
    );
endinterface

// File: rtl/buffer_elastico_operandos.sv
// Two-entry elastic buffer carrying mux words and their selector tags to the ALU operand latch,
// plus a saturating counter of cycles in which the ALU held off a valid operand.
module buffer_elastico_operandos #(
    parameter int ANCHO     = 16,
    parameter int ANCHO_ETQ = 2,
    parameter int ANCHO_CNT = 8
) (
    input  logic                          Reloj,
    input  logic                          Reset,
    buffer_elastico_operandos_if.slave    bus
);
    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        VACIO = 2'd0,
        UNO   = 2'd1,
        LLENO = 2'd2
    } estado_t;

    estado_t              state_q, state_d;
    logic [ANCHO-1:0]     head_data_q, head_data_d;
    logic [ANCHO_ETQ-1:0] head_tag_q, head_tag_d;
    logic [ANCHO-1:0]     tail_data_q, tail_data_d;
    logic [ANCHO_ETQ-1:0] tail_tag_q, tail_tag_d;
    logic [ANCHO_CNT-1:0] stall_cnt_q, stall_cnt_d;
    logic                 push;
    logic                 pop;

    always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset) begin
            state_q     <= VACIO;
            head_data_q <= '0;
            head_tag_q  <= '0;
            tail_data_q <= '0;
            tail_tag_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_tag_q  <= head_tag_d;
            tail_data_q <= tail_data_d;
            tail_tag_q  <= tail_tag_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_tag_d  = head_tag_q;
        tail_data_d = tail_data_q;
        tail_tag_d  = tail_tag_q;
        push        = bus.ValidoEntrada && (state_q != LLENO);
        pop         = (state_q != VACIO) && bus.ListoSalida;

        if (bus.Vaciar) begin
            state_d     = VACIO;
            head_data_d = '0;
            head_tag_d  = '0;
            tail_data_d = '0;
            tail_tag_d  = '0;
        end else begin
            unique case (state_q)
                VACIO: begin
                    if (push) begin
                        head_data_d = bus.Entrada;
                        head_tag_d  = bus.EtiquetaEntrada;
                        state_d     = UNO;
                    end
                end
                UNO: begin
                    if (push && pop) begin
                        head_data_d = bus.Entrada;
                        head_tag_d  = bus.EtiquetaEntrada;
                    end else if (push) begin
                        tail_data_d = bus.Entrada;
                        tail_tag_d  = bus.EtiquetaEntrada;
                        state_d     = LLENO;
                    end else if (pop) begin
                        head_data_d = '0;
                        head_tag_d  = '0;
                        state_d     = VACIO;
                    end
                end
                LLENO: begin
                    if (pop) begin
                        head_data_d = tail_data_q;
                        head_tag_d  = tail_tag_q;
                        tail_data_d = '0;
                        tail_tag_d  = '0;
                        state_d     = UNO;
                    end
                end
                default: begin
                    state_d = VACIO;
                end
            endcase
        end
    end

    // The stall counter ignores flushes and sticks at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q != VACIO) && !bus.ListoSalida && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign bus.ListoEntrada    = (state_q != LLENO);
    assign bus.ValidoSalida    = (state_q != VACIO);
    assign bus.Ocupacion       = state_q;
    assign bus.Salida          = head_data_q;
    assign bus.EtiquetaSalida  = head_tag_q;
    assign bus.ContadorEsperas = stall_cnt_q;
endmodule

// File: tb/tb_buffer_elastico_operandos.sv
// Bench for the operand elastic buffer: directed scenarios plus random traffic,
// all checked against a queue-based reference model of a 2-deep FIFO with a stall counter.
module tb_buffer_elastico_operandos;
    logic Reloj;
    logic Reset;

    buffer_elastico_operandos_if #(.ANCHO(16), .ANCHO_ETQ(2), .ANCHO_CNT(8)) bus ();

    buffer_elastico_operandos #(.ANCHO(16), .ANCHO_ETQ(2), .ANCHO_CNT(8)) dut (
        .Reloj (Reloj),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    int checkCount;
    int errorCount;
    logic [17:0] modelQ[$];
    int modelCnt;

    initial Reloj = 1'b0;
    always #5 Reloj = ~Reloj;

    task automatic checkOutput(input string tagName, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tagName, observed, expected, $time);
        end
    endtask

    // Compares every visible output against the model's view of the queue.
    task automatic checkModel();
        checkOutput("ocupacion", 32'(bus.Ocupacion), 32'(modelQ.size()));
        checkOutput("listoEntrada", 32'(bus.ListoEntrada), 32'(modelQ.size() != 2));
        checkOutput("validoSalida", 32'(bus.ValidoSalida), 32'(modelQ.size() != 0));
        checkOutput("contador", 32'(bus.ContadorEsperas), 32'(modelCnt));
        if (modelQ.size() != 0) begin
            checkOutput("salida", 32'(bus.Salida), 32'(modelQ[0][15:0]));
            checkOutput("etiqueta", 32'(bus.EtiquetaSalida), 32'(modelQ[0][17:16]));
        end
    endtask

    task automatic applyStimulus(input logic vin, input logic [15:0] d, input logic [1:0] t,
                                 input logic vac, input logic lsal);
        int size;
        bus.ValidoEntrada   = vin;
        bus.Entrada         = d;
        bus.EtiquetaEntrada = t;
        bus.Vaciar          = vac;
        bus.ListoSalida     = lsal;
        #1;
        checkModel();
        size = modelQ.size();
        @(posedge Reloj);
        if (size != 0 && !lsal && modelCnt < 255) modelCnt++;
        if (vac) begin
            modelQ.delete();
        end else begin
            if (size != 0 && lsal) void'(modelQ.pop_front());
            if (vin && size < 2) modelQ.push_back({t, d});
        end
        @(negedge Reloj);
    endtask

    task automatic checkCleared(input string where);
        checkOutput({where, "_ocup"}, 32'(bus.Ocupacion), 32'd0);
        checkOutput({where, "_valido"}, 32'(bus.ValidoSalida), 32'd0);
        checkOutput({where, "_salida"}, 32'(bus.Salida), 32'd0);
        checkOutput({where, "_etq"}, 32'(bus.EtiquetaSalida), 32'd0);
        checkOutput({where, "_listo"}, 32'(bus.ListoEntrada), 32'd1);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        modelCnt   = 0;
        Reset      = 1'b1;
        bus.ValidoEntrada   = 1'b0;
        bus.Entrada         = '0;
        bus.EtiquetaEntrada = '0;
        bus.Vaciar          = 1'b0;
        bus.ListoSalida     = 1'b0;
        repeat (2) @(negedge Reloj);
        Reset = 1'b0;
        #1;
        checkCleared("reset");
        checkOutput("reset_cnt", 32'(bus.ContadorEsperas), 32'd0);

        // Single word through an idle buffer.
        applyStimulus(1'b1, 16'h1234, 2'd2, 1'b0, 1'b1);
        checkOutput("s1_salida", 32'(bus.Salida), 32'h1234);
        checkOutput("s1_etq", 32'(bus.EtiquetaSalida), 32'd2);
        applyStimulus(1'b0, 16'h0, 2'd0, 1'b0, 1'b1);
        checkOutput("s1_vacio", 32'(bus.Ocupacion), 32'd0);

        // Fill, offer a third word while full, then drain with a re-offer.
        applyStimulus(1'b1, 16'hAAAA, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hBBBB, 2'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hCCCC, 2'd3, 1'b0, 1'b0);
        checkOutput("s2_lleno", 32'(bus.Ocupacion), 32'd2);
        checkOutput("s2_salida", 32'(bus.Salida), 32'hAAAA);
        applyStimulus(1'b1, 16'hCCCC, 2'd3, 1'b0, 1'b1);
        checkOutput("s2_segundo", 32'(bus.Salida), 32'hBBBB);
        applyStimulus(1'b1, 16'hCCCC, 2'd3, 1'b0, 1'b1);
        checkOutput("s2_tercero", 32'(bus.Salida), 32'hCCCC);
        checkOutput("s2_tercero_etq", 32'(bus.EtiquetaSalida), 32'd3);
        applyStimulus(1'b0, 16'h0, 2'd0, 1'b0, 1'b1);

        // Back-to-back streaming.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 16'(i), 2'(i), 1'b0, 1'b1);
            checkOutput("s3_ocup", 32'(bus.Ocupacion), 32'd1);
            checkOutput("s3_orden", 32'(bus.Salida), 32'(i));
        end
        applyStimulus(1'b0, 16'h0, 2'd0, 1'b0, 1'b1);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 250; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom),
                          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0));
        end

        // Flush while full with a simultaneous push attempt and pop.
        applyStimulus(1'b0, 16'h0, 2'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h1111, 2'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h2222, 2'd2, 1'b0, 1'b0);
        checkOutput("s5_lleno", 32'(bus.Ocupacion), 32'd2);
        applyStimulus(1'b1, 16'hDEAD, 2'd3, 1'b1, 1'b1);
        checkCleared("s5");

        // Long stall: counter must stick at 255.
        applyStimulus(1'b1, 16'h5A5A, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
        end
        checkOutput("s4_saturado", 32'(bus.ContadorEsperas), 32'd255);

        // Asynchronous reset between edges while full.
        applyStimulus(1'b1, 16'h7777, 2'd2, 1'b0, 1'b0);
        checkOutput("s6_lleno", 32'(bus.Ocupacion), 32'd2);
        #2 Reset = 1'b1;
        #1;
        checkCleared("s6");
        checkOutput("s6_cnt", 32'(bus.ContadorEsperas), 32'd0);
        modelQ.delete();
        modelCnt = 0;
        @(negedge Reloj);
        Reset = 1'b0;
        applyStimulus(1'b1, 16'h1234, 2'd2, 1'b0, 1'b1);
        checkOutput("s6_post_salida", 32'(bus.Salida), 32'h1234);
        applyStimulus(1'b0, 16'h0, 2'd0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
